// File: rtl/chay_step_ctrl.sv
// chay_step_ctrl: front-panel control for the two-LED running-light chaser.
// Synchronises and debounces three buttons (speed, pause, direction), keeps
// the run/direction/speed state and produces the one-cycle step pulse whose
// period is BASE_DIV * 2^(3-speed) clocks.
module chay_step_ctrl #(
  parameter int DEB_CYCLES = 500000,
  parameter int BASE_DIV   = 3125000
) (
  input  logic       clk,
  input  logic       rs,
  input  logic       btn_speed,
  input  logic       btn_pause,
  input  logic       btn_dir,
  output logic       step,
  output logic       dir,
  output logic       run,
  output logic [1:0] speed
);

  // Debounce counter only has to reach DEB_CYCLES-1.
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DC_LAST = DW'(DEB_CYCLES - 1);

  // Prescaler is sized for the slowest period (8 * BASE_DIV).
  localparam int CW = $clog2(8 * BASE_DIV);
  localparam logic [CW-1:0] PM1_S0 = CW'(8 * BASE_DIV - 1);
  localparam logic [CW-1:0] PM1_S1 = CW'(4 * BASE_DIV - 1);
  localparam logic [CW-1:0] PM1_S2 = CW'(2 * BASE_DIV - 1);
  localparam logic [CW-1:0] PM1_S3 = CW'(BASE_DIV - 1);

  // Button bit order: 0 = speed, 1 = pause, 2 = dir.
  logic [2:0]    btn_s;
  logic [2:0]    press_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] period_m1_s;

  assign btn_s = {btn_dir, btn_pause, btn_speed};

  for (genvar i = 0; i < 3; i++) begin : g_btn
    logic          s1_r;
    logic          s2_r;
    logic          deb_r;
    logic [DW-1:0] dc_r;

    // Synchronise the raw button and accept a new level after DEB_CYCLES stable samples.
    always_ff @(posedge clk) begin
      if (rs) begin
        s1_r  <= 1'b0;
        s2_r  <= 1'b0;
        deb_r <= 1'b0;
        dc_r  <= '0;
      end else begin
        s1_r <= btn_s[i];
        s2_r <= s1_r;
        if (s2_r == deb_r) begin
          dc_r <= '0;
        end else if (dc_r == DC_LAST) begin
          deb_r <= s2_r;
          dc_r  <= '0;
        end else begin
          dc_r <= dc_r + DW'(1);
        end
      end
    end

    // A press is the edge on which the debounced level rises; release is ignored.
    assign press_s[i] = s2_r & ~deb_r & (dc_r == DC_LAST);
  end

  // Select the terminal count of the prescaler for the current speed.
  always_comb begin
    period_m1_s = PM1_S0;
    case (speed)
      2'd0:    period_m1_s = PM1_S0;
      2'd1:    period_m1_s = PM1_S1;
      2'd2:    period_m1_s = PM1_S2;
      2'd3:    period_m1_s = PM1_S3;
      default: period_m1_s = PM1_S0;
    endcase
  end

  // Apply press actions to the user-visible state; simultaneous presses act independently.
  always_ff @(posedge clk) begin
    if (rs) begin
      speed <= 2'd0;
      run   <= 1'b1;
      dir   <= 1'b0;
    end else begin
      if (press_s[0]) begin
        speed <= speed + 2'd1;
      end
      if (press_s[1]) begin
        run <= ~run;
      end
      if (press_s[2]) begin
        dir <= ~dir;
      end
    end
  end

  // Prescaler and step pulse; uses run/speed before this edge's press updates.
  always_ff @(posedge clk) begin
    if (rs) begin
      cnt_r <= '0;
      step  <= 1'b0;
    end else if (press_s[0]) begin
      cnt_r <= '0;
      step  <= 1'b0;
    end else if (run) begin
      if (cnt_r == period_m1_s) begin
        cnt_r <= '0;
        step  <= 1'b1;
      end else begin
        cnt_r <= cnt_r + CW'(1);
        step  <= 1'b0;
      end
    end else begin
      step <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chay_step_ctrl.sv
// Self-checking bench for chay_step_ctrl with DEB_CYCLES=4, BASE_DIV=2.
// A behavioural model (integer counters and simple button pipelines) is
// advanced once per rising edge and compared with the DUT outputs.
module tb_chay_step_ctrl;

  localparam int DEB  = 4;
  localparam int BASE = 2;

  logic       clk = 1'b0;
  logic       rs = 1'b1;
  logic       btn_speed = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_dir = 1'b0;
  logic       step;
  logic       dir;
  logic       run;
  logic [1:0] speed;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int m_pipe [3][2];
  int m_deb [3];
  int m_len [3];
  int m_cnt;
  int m_speed;
  bit m_run;
  bit m_dir;
  bit m_step;

  chay_step_ctrl #(.DEB_CYCLES(DEB), .BASE_DIV(BASE)) dut (
    .clk(clk), .rs(rs), .btn_speed(btn_speed), .btn_pause(btn_pause),
    .btn_dir(btn_dir), .step(step), .dir(dir), .run(run), .speed(speed)
  );

  always #5 clk = ~clk;

  function automatic int period(int spd);
    return BASE * (1 << (3 - spd));
  endfunction

  function automatic logic [4:0] model_vec();
    return {m_step, m_dir, m_run, 2'(m_speed)};
  endfunction

  // Advance the model by one rising edge using the inputs sampled at that edge.
  task automatic model_edge();
    int btn [3];
    bit press [3];
    btn[0] = int'(btn_speed);
    btn[1] = int'(btn_pause);
    btn[2] = int'(btn_dir);
    if (rs) begin
      for (int b = 0; b < 3; b++) begin
        m_pipe[b][0] = 0; m_pipe[b][1] = 0; m_deb[b] = 0; m_len[b] = 0;
      end
      m_cnt = 0; m_speed = 0; m_run = 1'b1; m_dir = 1'b0; m_step = 1'b0;
      return;
    end
    for (int b = 0; b < 3; b++) begin
      press[b] = 1'b0;
      if (m_pipe[b][1] != m_deb[b]) begin
        m_len[b]++;
        if (m_len[b] == DEB) begin
          m_deb[b] = m_pipe[b][1];
          m_len[b] = 0;
          press[b] = (m_deb[b] == 1);
        end
      end else begin
        m_len[b] = 0;
      end
      m_pipe[b][1] = m_pipe[b][0];
      m_pipe[b][0] = btn[b];
    end
    if (press[0]) begin
      m_cnt = 0; m_step = 1'b0;
    end else if (m_run) begin
      if (m_cnt == period(m_speed) - 1) begin
        m_cnt = 0; m_step = 1'b1;
      end else begin
        m_cnt++; m_step = 1'b0;
      end
    end else begin
      m_step = 1'b0;
    end
    if (press[0]) m_speed = (m_speed + 1) % 4;
    if (press[1]) m_run = !m_run;
    if (press[2]) m_dir = !m_dir;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rs = 1'b1; btn_speed = 1'b0; btn_pause = 1'b0; btn_dir = 1'b0;
    tick();
    tick();
    checks++;
    if ({step, dir, run, speed} !== 5'b0_0_1_00) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", {step, dir, run, speed}, 5'b0_0_1_00);
    end
  endtask

  task automatic test_free_run();
    logic exp_step;
    rs = 1'b0;
    for (int e = 1; e <= 48; e++) begin
      tick();
      exp_step = ((e % 16) == 0);
      checks++;
      if ({step, dir, run, speed} !== {exp_step, 4'b0_1_00}) begin
        errors++;
        $display("FAIL free_run edge %0d: got %b want %b", e, {step, dir, run, speed}, {exp_step, 4'b0_1_00});
      end
    end
  endtask

  task automatic test_speed_cycle();
    int n;
    logic [1:0] exp_spd;
    for (int k = 0; k < 4; k++) begin
      exp_spd = 2'(k + 1);
      btn_speed = 1'b1;
      for (int t = 0; t < 6; t++) tick();
      checks++;
      if ({speed, step} !== {exp_spd, 1'b0}) begin
        errors++;
        $display("FAIL speed_press %0d: got speed/step %b want %b", k, {speed, step}, {exp_spd, 1'b0});
      end
      n = 0;
      while (n < 40) begin
        tick();
        n++;
        if (n == 2) btn_speed = 1'b0;
        checks++;
        if ({step, dir, run, speed} !== model_vec()) begin
          errors++;
          $display("FAIL speed_model: got %b want %b", {step, dir, run, speed}, model_vec());
        end
        if (step) break;
      end
      checks++;
      if (n !== period(int'(exp_spd))) begin
        errors++;
        $display("FAIL speed_period %0d: got %0d cycles want %0d", k, n, period(int'(exp_spd)));
      end
      btn_speed = 1'b0;
      for (int t = 0; t < 8; t++) tick();
    end
  endtask

  task automatic test_debounce();
    logic old_dir;
    logic exp_dir;
    old_dir = m_dir;
    btn_dir = 1'b1;
    for (int t = 0; t < 3; t++) tick();
    btn_dir = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      checks++;
      if (dir !== old_dir) begin
        errors++;
        $display("FAIL glitch_dir: got %b want %b", dir, old_dir);
      end
    end
    btn_dir = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_dir = (i >= 6) ? ~old_dir : old_dir;
      checks++;
      if (dir !== exp_dir) begin
        errors++;
        $display("FAIL hold_dir edge %0d: got %b want %b", i, dir, exp_dir);
      end
    end
    btn_dir = 1'b0;
    for (int t = 0; t < 10; t++) tick();
    checks++;
    if ({step, dir, run, speed} !== model_vec() || dir !== ~old_dir) begin
      errors++;
      $display("FAIL release_dir: got %b want %b", {step, dir, run, speed}, {model_vec()});
    end
  endtask

  task automatic test_pause_resume();
    int n;
    n = 0;
    while (!(m_cnt == 0 && m_run && m_speed == 0) && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL pause_sync: timeout got %0d want <100", n);
    end
    btn_pause = 1'b1;
    for (int t = 0; t < 6; t++) tick();
    checks++;
    if (run !== 1'b0) begin
      errors++;
      $display("FAIL pause_run: got %b want 0", run);
    end
    for (int t = 0; t < 22; t++) begin
      tick();
      if (t == 1) btn_pause = 1'b0;
      checks++;
      if (step !== 1'b0 || {step, dir, run, speed} !== model_vec()) begin
        errors++;
        $display("FAIL paused_step: got %b want %b", {step, dir, run, speed}, model_vec());
      end
    end
    btn_pause = 1'b1;
    for (int t = 0; t < 6; t++) tick();
    checks++;
    if ({run, step} !== 2'b10) begin
      errors++;
      $display("FAIL resume_run: got %b want 10", {run, step});
    end
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (n == 2) btn_pause = 1'b0;
      if (step) break;
    end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL resume_gap: got %0d cycles want 10", n);
    end
    for (int t = 0; t < 8; t++) tick();
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp_spd;
    logic exp_dir;
    int n;
    exp_spd = 2'(m_speed + 1);
    exp_dir = ~m_dir;
    btn_speed = 1'b1;
    btn_dir = 1'b1;
    for (int t = 0; t < 6; t++) tick();
    checks++;
    if ({speed, dir} !== {exp_spd, exp_dir}) begin
      errors++;
      $display("FAIL simul_press: got %b want %b", {speed, dir}, {exp_spd, exp_dir});
    end
    btn_speed = 1'b0;
    btn_dir = 1'b0;
    for (int t = 0; t < 10; t++) tick();
    n = 0;
    while (!(m_run && m_cnt == period(m_speed) - 6) && n < 100) begin
      tick();
      n++;
    end
    btn_pause = 1'b1;
    for (int t = 0; t < 6; t++) tick();
    checks++;
    if ({step, run} !== 2'b10 || n >= 100) begin
      errors++;
      $display("FAIL pause_on_wrap: got step/run %b want 10 (wait %0d)", {step, run}, n);
    end
    btn_pause = 1'b0;
    for (int t = 0; t < 8; t++) tick();
  endtask

  task automatic test_midrun_reset();
    int n;
    btn_dir = 1'b1;
    for (int t = 0; t < 4; t++) tick();
    rs = 1'b1;
    btn_dir = 1'b0;
    tick();
    rs = 1'b0;
    checks++;
    if ({step, dir, run, speed} !== 5'b0_0_1_00) begin
      errors++;
      $display("FAIL midrun_reset: got %b want %b", {step, dir, run, speed}, 5'b0_0_1_00);
    end
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (step) break;
    end
    checks++;
    if (n !== 16 || dir !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_step: got %0d cycles dir %b want 16 dir 0", n, dir);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(11) == 0) btn_speed = ~btn_speed;
      if ($urandom_range(11) == 0) btn_pause = ~btn_pause;
      if ($urandom_range(11) == 0) btn_dir = ~btn_dir;
      rs = ($urandom_range(499) == 0);
      tick();
      checks++;
      if ({step, dir, run, speed} !== model_vec()) begin
        errors++;
        $display("FAIL random cycle %0d: got %b want %b", t, {step, dir, run, speed}, model_vec());
      end
    end
    rs = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_speed_cycle();
    test_debounce();
    test_pause_resume();
    test_simultaneous();
    test_midrun_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
